// File: rtl/mdu_pkg.sv
`default_nettype none
//============================================================================
// Module   : mdu_pkg
// Desc     : Shared types and MDU operation codes for the mul/div controller.
// Revision : 1.0
//============================================================================
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MFHI  = 4'd7,
        MFLO  = 4'd8
    } md_type_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } mdu_state_e;

    localparam logic [2:0] MDU_OP_MTLO  = 3'b000;
    localparam logic [2:0] MDU_OP_MTHI  = 3'b001;
    localparam logic [2:0] MDU_OP_MULTU = 3'b010;
    localparam logic [2:0] MDU_OP_MULT  = 3'b011;
    localparam logic [2:0] MDU_OP_DIVU  = 3'b100;
    localparam logic [2:0] MDU_OP_DIV   = 3'b101;

    // Anything that is not an MDU command falls back to the all-zero code.
    function automatic logic [2:0] mdu_op_encode(input md_type_e t);
        logic [2:0] op;
        op = MDU_OP_MTLO;
        case (t)
            MULTU:   op = MDU_OP_MULTU;
            MULT:    op = MDU_OP_MULT;
            DIVU:    op = MDU_OP_DIVU;
            DIV:     op = MDU_OP_DIV;
            MTHI:    op = MDU_OP_MTHI;
            MTLO:    op = MDU_OP_MTLO;
            default: op = MDU_OP_MTLO;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_watchdog.sv
`default_nettype none
//============================================================================
// Module   : mdu_watchdog
// Desc     : WAIT-cycle counter with timeout pulse and sticky error flag.
// Revision : 1.0
//============================================================================
module mdu_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic res,
    input  logic i_wait,
    input  logic i_busy,
    output logic o_timeout,
    output logic o_err
);

    localparam int              CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // Fires on the TIMEOUT-th WAIT cycle if the MDU has still not released.
    assign o_timeout = i_wait & i_busy & (r_cnt == c_LAST);
    assign o_err     = r_err;

    always_ff @(posedge clk) begin
        if (res) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (i_wait && i_busy && !o_timeout) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (o_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
//============================================================================
// Module   : mdu_ctrl
// Desc     : E-stage sequencer for multiply/divide issue, HI/LO access, stall.
// Revision : 1.0
//============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        res,
    input  logic        md_valid,
    input  logic [3:0]  md_type,
    input  logic        flush,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mdu_busy,
    input  logic [31:0] mdu_hi,
    input  logic [31:0] mdu_lo,
    output logic        mdu_start,
    output logic        mdu_mt,
    output logic [2:0]  mdu_op,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    output logic        stall,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        err,
    output logic [31:0] stall_cnt
);

    md_type_e   w_type;
    mdu_state_e r_state;
    mdu_state_e w_state_nxt;
    logic       w_accept;
    logic       w_is_muldiv;
    logic       w_is_mt;
    logic       w_is_mf;
    logic       w_in_wait;
    logic       w_timeout;
    logic [31:0] r_stall_cnt;

    assign w_type      = md_type_e'(md_type);
    assign w_is_muldiv = (w_type == MULT) | (w_type == MULTU) |
                         (w_type == DIV)  | (w_type == DIVU);
    assign w_is_mt     = (w_type == MTHI) | (w_type == MTLO);
    assign w_is_mf     = (w_type == MFHI) | (w_type == MFLO);

    // A flushed instruction never holds the front end.
    assign stall    = md_valid & ~flush & (md_type != 4'd0) & (r_state != IDLE);
    assign w_accept = md_valid & ~flush & ~stall;

    assign mdu_op    = mdu_op_encode(w_type);
    assign mdu_a     = rs_val;
    assign mdu_b     = rt_val;
    assign rd_valid  = w_accept & w_is_mf;
    assign stall_cnt = r_stall_cnt;
    assign w_in_wait = (r_state == WAIT);

    always_comb begin
        rd_data = 32'd0;
        case (w_type)
            MFHI:    rd_data = mdu_hi;
            MFLO:    rd_data = mdu_lo;
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mdu_start   = 1'b0;
        mdu_mt      = 1'b0;
        case (r_state)
            IDLE: begin
                mdu_start = w_accept & w_is_muldiv;
                mdu_mt    = w_accept & w_is_mt;
                if (w_accept && w_is_muldiv) begin
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (!mdu_busy || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_stall_cnt <= 32'd0;
        end else if (stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    mdu_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .res       (res),
        .i_wait    (w_in_wait),
        .i_busy    (mdu_busy),
        .o_timeout (w_timeout),
        .o_err     (err)
    );

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
//============================================================================
// Module   : tb_mdu_ctrl
// Desc     : Directed self-checking bench for mdu_ctrl.
// Revision : 1.0
//============================================================================
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        res;
    logic        md_valid;
    logic [3:0]  md_type;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;
    logic        mdu_start;
    logic        mdu_mt;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_ctrl #(
        .TIMEOUT (16)
    ) u_dut (
        .clk       (clk),
        .res       (res),
        .md_valid  (md_valid),
        .md_type   (md_type),
        .flush     (flush),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mdu_busy  (mdu_busy),
        .mdu_hi    (mdu_hi),
        .mdu_lo    (mdu_lo),
        .mdu_start (mdu_start),
        .mdu_mt    (mdu_mt),
        .mdu_op    (mdu_op),
        .mdu_a     (mdu_a),
        .mdu_b     (mdu_b),
        .stall     (stall),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .err       (err),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input md_type_e t, input logic fl);
        md_valid = v;
        md_type  = t;
        flush    = fl;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b1; drive(1'b0, NONE, 1'b0);
        rs_val = '0; rt_val = '0; mdu_busy = 1'b0; mdu_hi = '0; mdu_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;

        // Reset state
        sample();
        check_eq("rst_stall", stall, 0);
        check_eq("rst_start", mdu_start, 0);
        check_eq("rst_mt", mdu_mt, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_stall_cnt", stall_cnt, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        advance();

        // MULT 0xFFFFFFFF * 2, followed by MFHI/MFLO
        drive(1'b1, MULT, 1'b0); rs_val = 32'hFFFF_FFFF; rt_val = 32'd2;
        sample();
        check_eq("mult_start", mdu_start, 1);
        check_eq("mult_op", mdu_op, 3'b011);
        check_eq("mult_a", mdu_a, 32'hFFFF_FFFF);
        check_eq("mult_b", mdu_b, 32'd2);
        check_eq("mult_c0_stall", stall, 0);
        advance();
        drive(1'b1, MFHI, 1'b0); mdu_busy = 1'b1;
        sample();
        check_eq("mult_c1_stall", stall, 1);
        check_eq("mult_c1_start", mdu_start, 0);
        check_eq("mult_c1_rdv", rd_valid, 0);
        advance();
        sample();
        check_eq("mult_c2_stall", stall, 1);
        advance();
        mdu_busy = 1'b0; mdu_hi = 32'hFFFF_FFFF; mdu_lo = 32'hFFFF_FFFE;
        sample();
        check_eq("mult_c3_stall", stall, 1);
        advance();
        sample();
        check_eq("mfhi_stall", stall, 0);
        check_eq("mfhi_rdv", rd_valid, 1);
        check_eq("mfhi_data", rd_data, 32'hFFFF_FFFF);
        check_eq("mfhi_op", mdu_op, 3'b000);
        check_eq("mult_stall_cnt", stall_cnt, 3);
        advance();
        drive(1'b1, MFLO, 1'b0);
        sample();
        check_eq("mflo_data", rd_data, 32'hFFFF_FFFE);
        check_eq("mflo_rdv", rd_valid, 1);
        advance();

        // DIVU 7/2 followed by a stalled MFLO
        drive(1'b1, DIVU, 1'b0); rs_val = 32'd7; rt_val = 32'd2;
        sample();
        check_eq("divu_start", mdu_start, 1);
        check_eq("divu_op", mdu_op, 3'b100);
        advance();
        drive(1'b1, MFLO, 1'b0); mdu_busy = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sample();
            check_eq("divu_wait_stall", stall, 1);
            check_eq("divu_wait_rdv", rd_valid, 0);
            advance();
        end
        mdu_busy = 1'b0; mdu_hi = 32'd1; mdu_lo = 32'd3;
        sample();
        check_eq("divu_rel_stall", stall, 1);
        advance();
        sample();
        check_eq("divu_mflo_stall", stall, 0);
        check_eq("divu_mflo_data", rd_data, 32'd3);
        check_eq("divu_mflo_rdv", rd_valid, 1);
        check_eq("divu_stall_cnt", stall_cnt, 7);
        advance();

        // MTHI / MTLO in IDLE with the MDU still busy
        drive(1'b1, MTHI, 1'b0); rs_val = 32'h1234_5678; mdu_busy = 1'b1;
        sample();
        check_eq("mthi_mt", mdu_mt, 1);
        check_eq("mthi_op", mdu_op, 3'b001);
        check_eq("mthi_stall", stall, 0);
        check_eq("mthi_start", mdu_start, 0);
        check_eq("mthi_a", mdu_a, 32'h1234_5678);
        advance();
        drive(1'b1, MFHI, 1'b0); mdu_hi = 32'h1234_5678;
        sample();
        check_eq("mthi_mfhi_stall", stall, 0);
        check_eq("mthi_mfhi_data", rd_data, 32'h1234_5678);
        check_eq("mthi_mfhi_rdv", rd_valid, 1);
        advance();
        drive(1'b1, MTLO, 1'b0);
        sample();
        check_eq("mtlo_mt", mdu_mt, 1);
        check_eq("mtlo_op", mdu_op, 3'b000);
        advance();

        // Flushed MULT: nothing issued, FSM stays IDLE
        drive(1'b1, MULT, 1'b1); mdu_busy = 1'b0;
        sample();
        check_eq("flush_start", mdu_start, 0);
        check_eq("flush_stall", stall, 0);
        check_eq("flush_rdv", rd_valid, 0);
        advance();
        drive(1'b1, MFLO, 1'b0); mdu_busy = 1'b1; mdu_lo = 32'hA5A5_A5A5;
        sample();
        check_eq("flush_next_stall", stall, 0);
        check_eq("flush_next_rdv", rd_valid, 1);
        check_eq("flush_next_data", rd_data, 32'hA5A5_A5A5);
        check_eq("flush_stall_cnt", stall_cnt, 7);
        advance();
        drive(1'b1, DIV, 1'b1);
        sample();
        check_eq("div_op", mdu_op, 3'b101);
        check_eq("div_flush_start", mdu_start, 0);
        advance();

        // Watchdog: MDU never releases
        drive(1'b1, MULT, 1'b0); mdu_busy = 1'b0;
        sample();
        check_eq("wd_start", mdu_start, 1);
        advance();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, MFLO, (i == 5)); mdu_busy = 1'b1;
            sample();
            if (i == 1) check_eq("wd_launch_stall", stall, 1);
            if (i == 5) check_eq("wd_flush_stall", stall, 0);
            if (i == 17) begin
                check_eq("wd_last_stall", stall, 1);
                check_eq("wd_err_before", err, 0);
            end
            advance();
        end
        drive(1'b1, MFLO, 1'b0);
        sample();
        check_eq("wd_err", err, 1);
        check_eq("wd_idle_stall", stall, 0);
        check_eq("wd_idle_rdv", rd_valid, 1);
        check_eq("wd_stall_cnt", stall_cnt, 23);
        advance();
        drive(1'b0, NONE, 1'b0); mdu_busy = 1'b0;
        repeat (2) advance();
        drive(1'b1, MULT, 1'b0);
        sample();
        check_eq("wd_err_hold0", err, 1);
        check_eq("wd_reissue_start", mdu_start, 1);
        advance();
        drive(1'b0, NONE, 1'b0);
        repeat (2) advance();
        sample();
        check_eq("wd_err_hold1", err, 1);
        check_eq("wd_stall_cnt_hold", stall_cnt, 23);
        advance();

        // Reset during WAIT
        drive(1'b1, MULT, 1'b0);
        sample();
        check_eq("rw_start", mdu_start, 1);
        advance();
        drive(1'b1, MFLO, 1'b0); mdu_busy = 1'b1;
        advance();
        res = 1'b1;
        sample();
        check_eq("rw_wait_stall", stall, 1);
        advance();
        res = 1'b0;
        sample();
        check_eq("rw_stall", stall, 0);
        check_eq("rw_stall_cnt", stall_cnt, 0);
        check_eq("rw_err", err, 0);
        check_eq("rw_rdv", rd_valid, 1);
        advance();

        // Back-to-back mul issues in the first IDLE cycle after WAIT
        drive(1'b1, MULT, 1'b0); mdu_busy = 1'b0; rs_val = 32'd3; rt_val = 32'd5;
        sample();
        check_eq("b2b_start0", mdu_start, 1);
        advance();
        drive(1'b1, MULTU, 1'b0); mdu_busy = 1'b1;
        sample();
        check_eq("b2b_launch_stall", stall, 1);
        check_eq("b2b_launch_start", mdu_start, 0);
        advance();
        mdu_busy = 1'b0;
        sample();
        check_eq("b2b_wait_stall", stall, 1);
        advance();
        sample();
        check_eq("b2b_start1", mdu_start, 1);
        check_eq("b2b_op", mdu_op, 3'b010);
        check_eq("b2b_stall", stall, 0);
        advance();
        drive(1'b0, NONE, 1'b0); mdu_busy = 1'b1;
        advance();
        mdu_busy = 1'b0;
        advance();
        sample();
        check_eq("b2b_stall_cnt", stall_cnt, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
